adc_seq_ctrl: RTL and testbench
===============================

// Module: adc_seq_ctrl
// PURPOSE
//  Initiator side of the ADC start/EOC/OE handshake. Triggers conversions periodically or on request.
//  Waits for end-of-conversion, strobes OE and captures the 12-bit result.
//  Delivers each result to the PID datapath as a one-cycle sample_valid pulse.
//  Flags handshake timeouts and trigger overruns.
// PARAMETERS
//  SAMPLE_PERIOD  1000  clk cycles between periodic triggers (>=2)
//  START_W        2     cycles start is held high (>=1)
//  OE_W           2     cycles oe is held high; data captured on last one (>=2)
//  EOC_TIMEOUT    255   max cycles waited in each EOC phase before error (>=1)
// PORTS
//  clk           in   1   clock, rising edge
//  rstn          in   1   reset, asynchronous, active-low
//  enable        in   1   1 = periodic triggering on
//  trig          in   1   single-cycle manual conversion request
//  eoc           in   1   ADC end-of-conversion (high when idle/done, low while converting), clk domain
//  adc_data      in   12  ADC result bus, valid while oe high (1 cycle after oe rises)
//  start         out  1   ADC start pulse
//  oe            out  1   ADC output enable
//  sample        out  12  last captured result
//  sample_valid  out  1   1-cycle pulse, sample updated this cycle
//  busy          out  1   1 when state != IDLE
//  timeout_err   out  1   1-cycle pulse on EOC timeout
//  overrun       out  1   1-cycle pulse: trigger arrived while busy (trigger dropped)
//  err_cnt       out  8   timeout count, saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, period/phase counters 0.
//  Reset is honoured in any state; start/oe drop at once.
//  Period counter:
//    - counts 0..SAMPLE_PERIOD-1 while enable=1.
//    - tick on value SAMPLE_PERIOD-1, then wraps to 0.
//    - held at 0 while enable=0.
//  req = tick | trig.
//    - req in IDLE: start conversion.
//    - req in any other state: overrun pulse next cycle; no queueing.
//  All outputs registered. FSM:
//    IDLE: start=0, oe=0.
//      On req -> START_HI; start=1 from next cycle.
//    START_HI: start=1 for exactly START_W cycles, then -> WAIT_LO with start=0.
//    WAIT_LO: wait eoc==0.
//      eoc==0 -> WAIT_HI.
//      EOC_TIMEOUT cycles without eoc==0 -> ERR.
//    WAIT_HI: wait eoc==1.
//      eoc==1 -> OE_HI.
//      EOC_TIMEOUT cycles without it -> ERR.
//      Phase timer restarts on entry.
//    OE_HI: oe=1 for exactly OE_W cycles.
//      On the last oe cycle adc_data is captured into sample.
//      sample_valid=1 in the following cycle, together with oe=0 and state IDLE.
//    ERR: one cycle; start=0, oe=0.
//      timeout_err=1 next cycle; err_cnt+1 (saturating).
//      -> IDLE. sample unchanged.
//  Latency: req to first start=1 is 1 cycle.
//  Result: sample_valid follows the eoc rise by OE_W+1 cycles.
//  enable=0 mid-conversion: current conversion completes normally; no new periodic trigger.
//  tick and trig in the same cycle: one conversion, no overrun.
//  sample holds until the next successful capture.
//  busy=1 in every state except IDLE.
// TESTING
//  1. Reset: rstn=0, then release -> all outputs 0; start stays 0 while enable=0 and trig=0.
//  2. Nominal, with adc model convert_time=10, SAMPLE_PERIOD=64, adc_data=12'hA5C:
//     start high 2 cycles, oe high 2 cycles, sample=12'hA5C, one sample_valid every 64 cycles.
//  3. eoc tied high, trig once -> after START_W+EOC_TIMEOUT cycles:
//     timeout_err pulse, err_cnt=1, busy=0, sample unchanged.
//  4. trig pulsed while in WAIT_HI -> overrun pulse, exactly one sample_valid for the running conversion.
//  5. rstn asserted in OE_HI -> start=0, oe=0, busy=0 immediately;
//     sample=0 and no sample_valid after release.
//  6. enable dropped during WAIT_HI -> one sample_valid, then no further start for 3*SAMPLE_PERIOD cycles.

Source files
------------

// File: rtl/adc_seq_ctrl.sv
// ADC conversion sequencer: drives start/oe against eoc and captures results.
// Periodic or manual triggering, with timeout and overrun reporting.
module adc_seq_ctrl #(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int START_W       = 2,
    parameter int OE_W          = 2,
    parameter int EOC_TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        trig,
    input  logic        eoc,
    input  logic [11:0] adc_data,
    output logic        start,
    output logic        oe,
    output logic [11:0] sample,
    output logic        sample_valid,
    output logic        busy,
    output logic        timeout_err,
    output logic        overrun,
    output logic [7:0]  err_cnt
);

    localparam int CW = $clog2(SAMPLE_PERIOD);
    localparam int M1 = (START_W > OE_W) ? START_W : OE_W;
    localparam int PH_MAX = (M1 > EOC_TIMEOUT) ? M1 : EOC_TIMEOUT;
    localparam int PW = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        START_HI,
        WAIT_LO,
        WAIT_HI,
        OE_HI,
        ERR
    } state_t;

    state_t        state;
    logic [CW-1:0] pcnt;
    logic [PW-1:0] ph;
    logic          tick;
    logic          req;

    assign tick = enable && (pcnt == CW'(SAMPLE_PERIOD - 1));
    assign req  = tick | trig;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcnt <= '0;
        end else if (!enable) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            ph           <= '0;
            start        <= 1'b0;
            oe           <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            overrun      <= 1'b0;
            err_cnt      <= '0;
        end else begin
            sample_valid <= 1'b0;
            timeout_err  <= 1'b0;
            // A request outside IDLE is dropped, only reported.
            overrun      <= req && (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (req) begin
                        state <= START_HI;
                        start <= 1'b1;
                        busy  <= 1'b1;
                        ph    <= '0;
                    end
                end
                START_HI: begin
                    if (ph == PW'(START_W - 1)) begin
                        state <= WAIT_LO;
                        start <= 1'b0;
                        ph    <= '0;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!eoc) begin
                        state <= WAIT_HI;
                        ph    <= '0;
                    end else if (ph == PW'(EOC_TIMEOUT - 1)) begin
                        state <= ERR;
                        ph    <= '0;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (eoc) begin
                        state <= OE_HI;
                        oe    <= 1'b1;
                        ph    <= '0;
                    end else if (ph == PW'(EOC_TIMEOUT - 1)) begin
                        state <= ERR;
                        ph    <= '0;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                OE_HI: begin
                    if (ph == PW'(OE_W - 1)) begin
                        state        <= IDLE;
                        oe           <= 1'b0;
                        busy         <= 1'b0;
                        sample       <= adc_data;
                        sample_valid <= 1'b1;
                        ph           <= '0;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                ERR: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    timeout_err <= 1'b1;
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    start <= 1'b0;
                    oe    <= 1'b0;
                    busy  <= 1'b0;
                    ph    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Directed bench for adc_seq_ctrl with a simple ADC behavioural model.
// Timing expectations are hand-derived cycle counts.
module tb_adc_seq_ctrl;

    localparam int P  = 64;
    localparam int SW = 2;
    localparam int OW = 2;
    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        trig = 1'b0;
    logic        eoc;
    logic [11:0] adc_data = 12'hA5C;
    logic        start;
    logic        oe;
    logic [11:0] sample;
    logic        sample_valid;
    logic        busy;
    logic        timeout_err;
    logic        overrun;
    logic [7:0]  err_cnt;

    logic eoc_m = 1'b1;
    logic tie = 1'b0;
    int   cc = 0;
    int   cyc = 0;
    int   sv_cnt = 0;
    int   ov_cnt = 0;
    int   st_cnt = 0;
    int   t_eoc = 0;
    logic start_q = 1'b0;
    logic eoc_q = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    assign eoc = tie ? 1'b1 : eoc_m;

    adc_seq_ctrl #(
        .SAMPLE_PERIOD(P),
        .START_W(SW),
        .OE_W(OW),
        .EOC_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .enable(enable),
        .trig(trig),
        .eoc(eoc),
        .adc_data(adc_data),
        .start(start),
        .oe(oe),
        .sample(sample),
        .sample_valid(sample_valid),
        .busy(busy),
        .timeout_err(timeout_err),
        .overrun(overrun),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // ADC model: eoc low for 10 cycles after the last start.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (start) begin
            eoc_m <= 1'b0;
            cc    <= 10;
        end else if (cc > 0) begin
            cc <= cc - 1;
            if (cc == 1) eoc_m <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (sample_valid) sv_cnt <= sv_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (start && !start_q) st_cnt <= st_cnt + 1;
        if (eoc && !eoc_q) t_eoc <= cyc;
        start_q <= start;
        eoc_q   <= eoc;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return start;
            1: return oe;
            2: return sample_valid;
            3: return eoc;
            4: return busy;
            default: return timeout_err;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int w, input logic val,
                            input int max);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < max; n++) begin
            if (sig(w) === val) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        int w;
        int n;
        int a;
        int sv0;
        int ov0;
        int st0;
        bit ok;

        // 1: reset
        steps(3);
        chk("rst_start", 32'(start), 0);
        chk("rst_oe", 32'(oe), 0);
        rstn = 1'b1;
        step();
        chk("rel_sample", 32'(sample), 0);
        chk("rel_busy", 32'(busy), 0);
        chk("rel_err_cnt", 32'(err_cnt), 0);
        chk("rel_flags", {29'd0, sample_valid, timeout_err, overrun}, 0);
        steps(20);
        chk("idle_no_start", 32'(st_cnt), 0);

        // 2: nominal periodic operation
        enable = 1'b1;
        wait_for("nom_start_wait", 0, 1'b1, 100);
        w = 1;
        step();
        while (start && w < 10) begin
            w++;
            step();
        end
        chk("nom_start_width", 32'(w), SW);
        wait_for("nom_oe_wait", 1, 1'b1, 50);
        w = 1;
        step();
        while (oe && w < 10) begin
            w++;
            step();
        end
        chk("nom_oe_width", 32'(w), OW);
        wait_for("nom_sv_wait", 2, 1'b1, 10);
        chk("nom_sample", 32'(sample), 32'hA5C);
        chk("nom_eoc_to_sv", 32'(cyc - t_eoc), OW + 1);
        a = cyc;
        step();
        wait_for("nom_sv2_wait", 2, 1'b1, 100);
        chk("nom_period", 32'(cyc - a), P);
        enable = 1'b0;
        wait_for("nom_idle", 4, 1'b0, 100);
        steps(2);

        // 4: trig during WAIT_HI
        adc_data = 12'h5B7;
        sv0 = sv_cnt;
        trig = 1'b1;
        step();
        trig = 1'b0;
        wait_for("ovr_eoc_lo", 3, 1'b0, 20);
        steps(2);
        ov0 = ov_cnt;
        st0 = st_cnt;
        trig = 1'b1;
        step();
        trig = 1'b0;
        chk("ovr_pulse", 32'(overrun), 1);
        steps(25);
        chk("ovr_count", 32'(ov_cnt - ov0), 1);
        chk("ovr_sv_count", 32'(sv_cnt - sv0), 1);
        chk("ovr_no_restart", 32'(st_cnt - st0), 0);
        chk("ovr_sample", 32'(sample), 32'h5B7);
        chk("ovr_busy", 32'(busy), 0);

        // 3: eoc stuck high
        tie = 1'b1;
        adc_data = 12'h3C1;
        sv0 = sv_cnt;
        step();
        trig = 1'b1;
        step();
        trig = 1'b0;
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (timeout_err) begin
                ok = 1'b1;
                break;
            end
            step();
            n++;
        end
        chk("to_seen", 32'(ok), 1);
        chk("to_latency", 32'(n), SW + TO + 1);
        chk("to_err_cnt", 32'(err_cnt), 1);
        chk("to_busy", 32'(busy), 0);
        step();
        chk("to_pulse_end", 32'(timeout_err), 0);
        chk("to_sample", 32'(sample), 32'h5B7);
        chk("to_no_sv", 32'(sv_cnt - sv0), 0);
        tie = 1'b0;
        steps(15);

        // 5: reset during OE_HI
        trig = 1'b1;
        step();
        trig = 1'b0;
        wait_for("rst_oe_wait", 1, 1'b1, 40);
        rstn = 1'b0;
        #1;
        chk("arst_start", 32'(start), 0);
        chk("arst_oe", 32'(oe), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_err_cnt", 32'(err_cnt), 0);
        sv0 = sv_cnt;
        steps(3);
        rstn = 1'b1;
        steps(20);
        chk("arst_sample", 32'(sample), 0);
        chk("arst_no_sv", 32'(sv_cnt - sv0), 0);

        // 6: enable dropped during WAIT_HI
        adc_data = 12'h0F3;
        enable = 1'b1;
        wait_for("dis_eoc_lo", 3, 1'b0, 150);
        steps(2);
        enable = 1'b0;
        sv0 = sv_cnt;
        st0 = st_cnt;
        steps(3 * P + 20);
        chk("dis_sv_count", 32'(sv_cnt - sv0), 1);
        chk("dis_no_start", 32'(st_cnt - st0), 0);
        chk("dis_sample", 32'(sample), 32'h0F3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
